// File: rtl/block_window_fetcher_if.sv
// BRAM read port shared by the left and right frame memories.
// The fetcher drives the addresses (master); the memory returns the pixels two cycles later (slave).
`timescale 1ns/1ps
interface block_window_fetcher_if #(
  parameter int AW    = 17,
  parameter int PIX_W = 8
);
  logic [AW-1:0]    left_addr_out;
  logic [AW-1:0]    right_addr_out;
  logic [PIX_W-1:0] left_pix_in;
  logic [PIX_W-1:0] right_pix_in;

  modport master (
    output left_addr_out,
    output right_addr_out,
    input  left_pix_in,
    input  right_pix_in
  );

  modport slave (
    input  left_addr_out,
    input  right_addr_out,
    output left_pix_in,
    output right_pix_in
  );
endinterface

// File: rtl/block_window_fetcher.sv
// Fetches a 6x12 pixel window (front block plus the block to its right) from
// the left and right frame BRAMs in lockstep, zero-filling pixels that fall
// outside the image, and presents both 6x6 blocks of each frame at valid_out.
`timescale 1ns/1ps
module block_window_fetcher #(
  parameter int IMG_WIDTH  = 240,
  parameter int IMG_HEIGHT = 320,
  parameter int BLOCK      = 6,
  parameter int PIX_W      = 8
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 start_in,
  input  logic [8:0]                           left_x_in,
  input  logic [8:0]                           right_x_in,
  input  logic [9:0]                           left_y_in,
  input  logic [9:0]                           right_y_in,
  input  logic [8:0]                           left_block_idx_in,
  input  logic [8:0]                           right_block_idx_in,
  block_window_fetcher_if.master               bram,
  output logic                                 busy_out,
  output logic                                 valid_out,
  output logic [8:0]                           left_current_x,
  output logic [8:0]                           right_current_x,
  output logic [9:0]                           left_current_y,
  output logic [9:0]                           right_current_y,
  output logic [8:0]                           left_block_idx,
  output logic [8:0]                           right_block_idx,
  output logic [BLOCK-1:0][BLOCK*PIX_W-1:0]    left_front_buffer,
  output logic [BLOCK-1:0][BLOCK*PIX_W-1:0]    left_back_buffer,
  output logic [BLOCK-1:0][BLOCK*PIX_W-1:0]    right_front_buffer,
  output logic [BLOCK-1:0][BLOCK*PIX_W-1:0]    right_back_buffer
);

  localparam int AW   = 17;
  localparam int RW   = $clog2(BLOCK);
  localparam int CW   = $clog2(2 * BLOCK);
  localparam int ROWB = BLOCK * PIX_W;
  localparam int OW   = $clog2(ROWB);
  localparam logic [RW-1:0] ROW_LAST = RW'(BLOCK - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(2 * BLOCK - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN, ST_DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic            r_drain;
  logic            r_busy;
  logic            r_valid;
  logic            w_accept;
  logic            w_issue;
  logic            w_last_read;

  // Read-return pipeline: row/column of each read, aligned to the 2-cycle BRAM latency
  logic            r_vld_s1, r_vld_s2;
  logic [RW-1:0]   r_row_s1, r_row_s2;
  logic [CW-1:0]   r_col_s1, r_col_s2;
  logic            w_is_front;
  logic [CW-1:0]   w_bcol;
  logic [OW-1:0]   w_bit_off;

  // Per-frame views of the request and read data so both frames share one generate body
  logic [8:0]       w_x_in   [2];
  logic [9:0]       w_y_in   [2];
  logic [8:0]       w_idx_in [2];
  logic [PIX_W-1:0] w_pix_in [2];

  assign w_x_in[0]   = left_x_in;
  assign w_x_in[1]   = right_x_in;
  assign w_y_in[0]   = left_y_in;
  assign w_y_in[1]   = right_y_in;
  assign w_idx_in[0] = left_block_idx_in;
  assign w_idx_in[1] = right_block_idx_in;
  assign w_pix_in[0] = bram.left_pix_in;
  assign w_pix_in[1] = bram.right_pix_in;

  // A start pulse arriving while valid_out is still high is deliberately dropped
  assign w_accept    = (r_state == ST_IDLE) && start_in && !r_valid;
  assign w_issue     = (r_state == ST_FETCH);
  assign w_last_read = (r_row == ROW_LAST) && (r_col == COL_LAST);

  // Columns 0..BLOCK-1 land in the front block, the rest in the back block
  assign w_is_front = (r_col_s2 < CW'(BLOCK));
  assign w_bcol     = w_is_front ? r_col_s2 : (r_col_s2 - CW'(BLOCK));
  assign w_bit_off  = OW'((BLOCK - 1 - int'(w_bcol)) * PIX_W);

  // Next-state logic: fetch all reads, wait out the BRAM latency, then publish once
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = ST_FETCH;
      ST_FETCH: if (w_last_read) w_state_next = ST_DRAIN;
      ST_DRAIN: if (r_drain) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Shared control: state, read counters, handshake flags and the return pipeline
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state  <= ST_IDLE;
      r_row    <= '0;
      r_col    <= '0;
      r_drain  <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_vld_s1 <= 1'b0;
      r_vld_s2 <= 1'b0;
      r_row_s1 <= '0;
      r_row_s2 <= '0;
      r_col_s1 <= '0;
      r_col_s2 <= '0;
    end else begin
      r_state <= w_state_next;
      r_valid <= (r_state == ST_DONE);
      if (w_accept) begin
        r_busy <= 1'b1;
      end else if (r_valid) begin
        r_busy <= 1'b0;
      end
      if (w_accept) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_issue) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : (r_row + RW'(1));
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      r_drain  <= (r_state == ST_DRAIN) ? ~r_drain : 1'b0;
      r_vld_s1 <= w_issue;
      r_vld_s2 <= r_vld_s1;
      r_row_s1 <= r_row;
      r_row_s2 <= r_row_s1;
      r_col_s1 <= r_col;
      r_col_s2 <= r_col_s1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_frame
      logic [8:0]                r_req_x;
      logic [9:0]                r_req_y;
      logic [8:0]                r_req_idx;
      logic [9:0]                w_x_sum;
      logic [10:0]               w_y_sum;
      logic                      w_oor;
      logic [AW-1:0]             w_addr;
      logic [PIX_W-1:0]          w_pix_val;
      logic                      r_oor_s1;
      logic                      r_oor_s2;
      logic [BLOCK-1:0][ROWB-1:0] r_work_front;
      logic [BLOCK-1:0][ROWB-1:0] r_work_back;
      logic [BLOCK-1:0][ROWB-1:0] r_out_front;
      logic [BLOCK-1:0][ROWB-1:0] r_out_back;
      logic [8:0]                r_out_x;
      logic [9:0]                r_out_y;
      logic [8:0]                r_out_idx;

      // Sums are one bit wider than the request so x+11 / y+5 never wrap
      assign w_x_sum   = {1'b0, r_req_x} + 10'(r_col);
      assign w_y_sum   = {1'b0, r_req_y} + 11'(r_row);
      assign w_oor     = (w_x_sum >= 10'(IMG_WIDTH)) || (w_y_sum >= 11'(IMG_HEIGHT));
      // In-range addresses fit 17 bits; out-of-range reads park the bus at 0
      assign w_addr    = (w_issue && !w_oor) ?
                         (AW'(w_y_sum) * AW'(IMG_WIDTH) + AW'(w_x_sum)) : '0;
      assign w_pix_val = r_oor_s2 ? '0 : w_pix_in[gi];

      // Capture request, steer returning pixels into the working blocks, publish on DONE
      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          r_req_x      <= '0;
          r_req_y      <= '0;
          r_req_idx    <= '0;
          r_oor_s1     <= 1'b0;
          r_oor_s2     <= 1'b0;
          r_work_front <= '0;
          r_work_back  <= '0;
          r_out_front  <= '0;
          r_out_back   <= '0;
          r_out_x      <= '0;
          r_out_y      <= '0;
          r_out_idx    <= '0;
        end else begin
          if (w_accept) begin
            r_req_x   <= w_x_in[gi];
            r_req_y   <= w_y_in[gi];
            r_req_idx <= w_idx_in[gi];
          end
          r_oor_s1 <= w_oor;
          r_oor_s2 <= r_oor_s1;
          if (r_vld_s2) begin
            if (w_is_front) begin
              r_work_front[r_row_s2][w_bit_off +: PIX_W] <= w_pix_val;
            end else begin
              r_work_back[r_row_s2][w_bit_off +: PIX_W] <= w_pix_val;
            end
          end
          // Outputs change only here, so they hold steady between valid_out pulses
          if (r_state == ST_DONE) begin
            r_out_front <= r_work_front;
            r_out_back  <= r_work_back;
            r_out_x     <= r_req_x;
            r_out_y     <= r_req_y;
            r_out_idx   <= r_req_idx;
          end
        end
      end
    end
  endgenerate

  assign bram.left_addr_out  = gen_frame[0].w_addr;
  assign bram.right_addr_out = gen_frame[1].w_addr;
  assign busy_out            = r_busy;
  assign valid_out           = r_valid;
  assign left_current_x      = gen_frame[0].r_out_x;
  assign right_current_x     = gen_frame[1].r_out_x;
  assign left_current_y      = gen_frame[0].r_out_y;
  assign right_current_y     = gen_frame[1].r_out_y;
  assign left_block_idx      = gen_frame[0].r_out_idx;
  assign right_block_idx     = gen_frame[1].r_out_idx;
  assign left_front_buffer   = gen_frame[0].r_out_front;
  assign left_back_buffer    = gen_frame[0].r_out_back;
  assign right_front_buffer  = gen_frame[1].r_out_front;
  assign right_back_buffer   = gen_frame[1].r_out_back;

endmodule

// File: tb/tb_block_window_fetcher.sv
// Scoreboard bench for block_window_fetcher: each accepted request pushes its
// expected window into a queue; a monitor pops and compares on every valid_out.
`timescale 1ns/1ps
module tb_block_window_fetcher;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic              rst_in;
  logic              start_in;
  logic [8:0]        lx, rx, lidx, ridx;
  logic [9:0]        ly, ry;
  logic              busy_out, valid_out;
  logic [8:0]        left_current_x, right_current_x, left_block_idx, right_block_idx;
  logic [9:0]        left_current_y, right_current_y;
  logic [5:0][47:0]  left_front_buffer, left_back_buffer, right_front_buffer, right_back_buffer;

  block_window_fetcher_if #(.AW(17), .PIX_W(8)) bif ();

  block_window_fetcher dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .start_in           (start_in),
    .left_x_in          (lx),
    .right_x_in         (rx),
    .left_y_in          (ly),
    .right_y_in         (ry),
    .left_block_idx_in  (lidx),
    .right_block_idx_in (ridx),
    .bram               (bif),
    .busy_out           (busy_out),
    .valid_out          (valid_out),
    .left_current_x     (left_current_x),
    .right_current_x    (right_current_x),
    .left_current_y     (left_current_y),
    .right_current_y    (right_current_y),
    .left_block_idx     (left_block_idx),
    .right_block_idx    (right_block_idx),
    .left_front_buffer  (left_front_buffer),
    .left_back_buffer   (left_back_buffer),
    .right_front_buffer (right_front_buffer),
    .right_back_buffer  (right_back_buffer)
  );

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // BRAM model: mode 0 -> every pixel 0x64, mode 1 -> pixel = addr mod 256; 2-cycle latency
  int mode = 0;
  function automatic logic [7:0] pix_of(int a);
    return (mode == 0) ? 8'h64 : 8'(a);
  endfunction

  logic [7:0] p1_l, p1_r;
  always @(posedge clk_in) begin
    p1_l             <= pix_of(int'(bif.left_addr_out));
    p1_r             <= pix_of(int'(bif.right_addr_out));
    bif.left_pix_in  <= p1_l;
    bif.right_pix_in <= p1_r;
  end

  typedef struct {
    int               e;
    logic [8:0]       x_l, x_r, i_l, i_r;
    logic [9:0]       y_l, y_r;
    logic [5:0][47:0] lf, lb, rf, rb;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int ntx    = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Reference window row: 6 pixels starting at column x+coff of row y+r, zero outside the image
  function automatic logic [47:0] exp_row(int x, int y, int r, int coff);
    logic [47:0] v;
    v = '0;
    for (int c = 0; c < 6; c++) begin
      int xx;
      int yy;
      xx = x + coff + c;
      yy = y + r;
      if (xx < 240 && yy < 320) v[(5 - c) * 8 +: 8] = pix_of(yy * 240 + xx);
    end
    return v;
  endfunction

  task automatic push_exp(int e0, int xl, int yl, int xr, int yr, int il, int ir);
    exp_t e;
    e.e   = e0 + 75;
    e.x_l = 9'(xl);  e.y_l = 10'(yl);  e.i_l = 9'(il);
    e.x_r = 9'(xr);  e.y_r = 10'(yr);  e.i_r = 9'(ir);
    for (int r = 0; r < 6; r++) begin
      e.lf[r] = exp_row(xl, yl, r, 0);
      e.lb[r] = exp_row(xl, yl, r, 6);
      e.rf[r] = exp_row(xr, yr, r, 0);
      e.rb[r] = exp_row(xr, yr, r, 6);
    end
    q.push_back(e);
  endtask

  // Monitor: compares every valid_out against the oldest expectation, then checks the pulse ends
  bit prev_valid = 1'b0;
  always @(negedge clk_in) begin
    exp_t e;
    if (prev_valid) begin
      chk("valid_one_cycle", 64'(valid_out), 64'(0));
      chk("busy_fall", 64'(busy_out), 64'(0));
    end
    if (valid_out) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid_out=1 at edge %0d, required 0", cyc);
      end else begin
        e = q.pop_front();
        ntx++;
        chk("valid_edge", 64'(cyc), 64'(e.e));
        chk("busy_at_valid", 64'(busy_out), 64'(1));
        chk("left_x", 64'(left_current_x), 64'(e.x_l));
        chk("left_y", 64'(left_current_y), 64'(e.y_l));
        chk("left_idx", 64'(left_block_idx), 64'(e.i_l));
        chk("right_x", 64'(right_current_x), 64'(e.x_r));
        chk("right_y", 64'(right_current_y), 64'(e.y_r));
        chk("right_idx", 64'(right_block_idx), 64'(e.i_r));
        for (int r = 0; r < 6; r++) begin
          chk($sformatf("left_front[%0d]", r), 64'(left_front_buffer[r]), 64'(e.lf[r]));
          chk($sformatf("left_back[%0d]", r), 64'(left_back_buffer[r]), 64'(e.lb[r]));
          chk($sformatf("right_front[%0d]", r), 64'(right_front_buffer[r]), 64'(e.rf[r]));
          chk($sformatf("right_back[%0d]", r), 64'(right_back_buffer[r]), 64'(e.rb[r]));
        end
        $display("txn %0d: valid_out at edge %0d (required %0d) L(%0d,%0d) R(%0d,%0d) errors so far %0d",
                 ntx, cyc, e.e, e.x_l, e.y_l, e.x_r, e.y_r, errors);
      end
    end
    prev_valid = valid_out;
  end

  task automatic drive_req(int xl, int yl, int xr, int yr, int il, int ir);
    lx = 9'(xl);  ly = 10'(yl);  lidx = 9'(il);
    rx = 9'(xr);  ry = 10'(yr);  ridx = 9'(ir);
  endtask

  // One-cycle start pulse; returns E0 (edge count at acceptance) and optionally queues the expectation
  task automatic issue(int xl, int yl, int xr, int yr, int il, int ir, bit push, output int e0);
    @(negedge clk_in);
    drive_req(xl, yl, xr, yr, il, ir);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    e0 = cyc;
    if (push) push_exp(e0, xl, yl, xr, yr, il, ir);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL valid_timeout: got %0d pending windows after %0d cycles, required 0", q.size(), n);
      q.delete();
    end
    repeat (3) @(negedge clk_in);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_busy"}, 64'(busy_out), 64'(0));
    chk({tag, "_valid"}, 64'(valid_out), 64'(0));
    chk({tag, "_laddr"}, 64'(bif.left_addr_out), 64'(0));
    chk({tag, "_raddr"}, 64'(bif.right_addr_out), 64'(0));
    chk({tag, "_tags"}, 64'({left_current_x, right_current_x, left_block_idx, right_block_idx,
                              left_current_y, right_current_y}), 64'(0));
    for (int r = 0; r < 6; r++) begin
      chk($sformatf("%s_bufs[%0d]", tag, r),
          64'(left_front_buffer[r] | left_back_buffer[r] | right_front_buffer[r] | right_back_buffer[r]),
          64'(0));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int n;
    rst_in   = 1'b0;
    start_in = 1'b0;
    drive_req(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk_in);
    check_all_zero("reset");
    rst_in = 1'b1;

    // Constant 0x64 memory, both frames at origin
    mode = 0;
    issue(0, 0, 0, 0, 5, 9, 1'b1, e0);
    wait_drain();

    // addr mod 256 memory, right frame shifted by 2
    mode = 1;
    issue(0, 0, 2, 0, 1, 2, 1'b1, e0);
    wait_drain();
    chk("hand_right_front1", 64'(right_front_buffer[1]), 64'h0000_F2F3F4F5F6F7);
    chk("hand_left_front0", 64'(left_front_buffer[0]), 64'h0000_000102030405);
    chk("hand_left_back0", 64'(left_back_buffer[0]), 64'h0000_060708090A0B);

    // Right edge: back block of left frame entirely outside
    issue(234, 0, 100, 50, 3, 4, 1'b1, e0);
    wait_drain();
    chk("hand_edge_back0", 64'(left_back_buffer[0]), 64'(0));
    chk("hand_edge_front0", 64'(left_front_buffer[0]), 64'h0000_EAEBECEDEEEF);

    // Bottom edge and bottom-right corner
    issue(10, 317, 239, 319, 6, 7, 1'b1, e0);
    wait_drain();
    chk("hand_bottom_front3", 64'(left_front_buffer[3]), 64'(0));
    chk("hand_bottom_front2", 64'(left_front_buffer[2]), 64'h0000_1A1B1C1D1E1F);
    chk("hand_corner_front0", 64'(right_front_buffer[0]), 64'h0000_FF0000000000);

    // Second start pulse while busy at E0+10 with different inputs must be ignored
    issue(20, 30, 40, 50, 7, 8, 1'b1, e0);
    repeat (9) @(negedge clk_in);
    drive_req(100, 100, 100, 100, 99, 98);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    wait_drain();
    repeat (100) @(negedge clk_in);

    // Start held across the valid_out cycle: ignored there, accepted the cycle after
    issue(5, 6, 7, 8, 11, 12, 1'b1, e0);
    n = 0;
    while (!valid_out && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    chk("valid_seen_for_hold", 64'(valid_out), 64'(1));
    drive_req(50, 60, 70, 80, 13, 14);
    start_in = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    start_in = 1'b0;
    chk("accept_edge_after_valid", 64'(cyc), 64'(e0 + 77));
    push_exp(cyc, 50, 60, 70, 80, 13, 14);
    wait_drain();

    // Reset in the middle of a fetch clears everything and yields no valid_out
    issue(0, 0, 0, 0, 1, 1, 1'b0, e0);
    repeat (30) @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (100) @(negedge clk_in);
    chk("idle_after_reset", 64'(busy_out), 64'(0));

    // Normal fetch after reset
    issue(3, 4, 5, 6, 21, 22, 1'b1, e0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/block_window_fetcher.md
BLOCK_WINDOW_FETCHER -- requirements
Module: block_window_fetcher

Interface
REQ-001 Parameter IMG_WIDTH, default 240, image width in pixels (x range).
REQ-002 Parameter IMG_HEIGHT, default 320, image height in pixels (y range).
REQ-003 Parameter BLOCK, default 6, block edge in pixels; PIX_W, default 8, pixel width in bits.
REQ-004 clk_in  input  1  single system clock, all logic on rising edge.
REQ-005 rst_in  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 start_in  input  1  fetch request, sampled only in IDLE.
REQ-007 left_x_in, right_x_in  input  9 each  left column of the front block in each frame.
REQ-008 left_y_in, right_y_in  input  10 each  top row of the block in each frame.
REQ-009 left_block_idx_in, right_block_idx_in  input  9 each  tags, passed through unchanged.
REQ-010 left_addr_out, right_addr_out  output  17 each  frame BRAM read address.
REQ-011 left_pix_in, right_pix_in  input  8 each  BRAM read data, fixed 2-cycle read latency.
REQ-012 busy_out  output  1  high from start acceptance until valid_out pulse inclusive.
REQ-013 valid_out  output  1  one-cycle pulse, all buffers and tags valid.
REQ-014 left_current_x, right_current_x (9), left_current_y, right_current_y (10), left_block_idx, right_block_idx (9)  outputs  registered copies of the request.
REQ-015 left_front_buffer, left_back_buffer, right_front_buffer, right_back_buffer  output  6 x 48 each  row r of the 6x6 block; column 0 in bits [47:40], column 5 in [7:0].

Function
REQ-016 States SHALL be IDLE, FETCH, DRAIN, DONE.
REQ-017 IDLE -> FETCH on start_in=1; request inputs SHALL be registered on that edge (edge E0).
REQ-018 start_in while busy_out=1 SHALL be ignored; no effect on the fetch in flight.
REQ-019 FETCH SHALL issue one read per cycle per frame, 72 reads: row 0..5 outer, column 0..11 inner.
REQ-020 Columns 0..5 SHALL fill the front buffer; columns 6..11 SHALL fill the back buffer (x+6..x+11).
REQ-021 Address SHALL be (y+row)*IMG_WIDTH + (x+col), computed in 17 bits without truncation.
REQ-022 Pixel with x+col >= IMG_WIDTH or y+row >= IMG_HEIGHT SHALL be written as 0; address output SHALL then be 0.
REQ-023 An out-of-range flag SHALL travel with each read through a 2-stage pipeline aligned to BRAM latency.
REQ-024 FETCH -> DRAIN after the 72nd read; DRAIN SHALL last 2 cycles to capture the last data.
REQ-025 DRAIN -> DONE; DONE SHALL assert valid_out for exactly one cycle, then -> IDLE.
REQ-026 valid_out SHALL rise on the 75th rising edge after E0; busy_out SHALL fall on the edge after valid_out.
REQ-027 Buffers and tag outputs SHALL hold value from valid_out until the next valid_out.
REQ-028 Left and right frames SHALL be fetched in lockstep with identical row/column counters.
REQ-029 start_in asserted in the cycle valid_out is high SHALL be ignored; accepted in the following IDLE cycle.

Reset
REQ-030 rst_in=0 SHALL immediately force IDLE, busy_out=0, valid_out=0, addresses 0, all buffers and tag outputs 0.
REQ-031 Reset mid-fetch SHALL abandon the fetch; no valid_out SHALL follow; pipeline flags cleared.
REQ-032 After rst_in returns to 1, the first start_in on a rising edge SHALL be accepted normally.

Verification
REQ-033 BRAM model: every pixel 0x64, request x=0,y=0 both frames -> valid_out at edge 75, all 24 rows = 0x646464646464.
REQ-034 Pixel value = (addr mod 256), left x=0,y=0, right x=2,y=0 -> right_front_buffer[1] = bytes 0xF2,0xF3,0xF4,0xF5,0xF6,0xF7 (addr 242..247).
REQ-035 left x=234,y=0 -> left_back_buffer rows all 0 (columns 240..245 out of range); front intact.
REQ-036 left y=317 -> left_front_buffer[3..5]=0, rows 0..2 from BRAM.
REQ-037 start_in pulsed again at E0+10 -> ignored; exactly one valid_out at edge 75.
REQ-038 rst_in low at E0+30 for 1 cycle -> outputs 0 at once, no valid_out; new start then -> valid_out 75 edges later.
